// File: rtl/sdram_frame_arbiter.sv
// Purpose: shares the SDRAM Wishbone port between display reads (priority) and capture writes (anti-starvation streak).
// Latency: grant is combinational in IDLE, the Wishbone cycle starts the next clock, and read beats return one clock after ack.
// Backpressure: wb_ack_i wait states freeze the bus; wr_ack paces the writer, and requests are only sampled in IDLE.
module sdram_frame_arbiter #(
  parameter int DW            = 32,
  parameter int BL_W          = 9,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic            wb_clk_i,
  input  logic            RESETN,
  input  logic            sdr_init_done,
  input  logic            rd_req,
  input  logic [24:0]     rd_addr,
  input  logic [BL_W-1:0] rd_len,
  output logic            rd_gnt,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            rd_done,
  input  logic            wr_req,
  input  logic [24:0]     wr_addr,
  input  logic [BL_W-1:0] wr_len,
  output logic            wr_gnt,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_ack,
  output logic            wr_done,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [24:0]     wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int              SW         = $clog2(MAX_RD_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_RD_STREAK);
  localparam logic [24:0]     ADDR_STEP  = 25'(DW / 8);
  localparam logic [BL_W-1:0] ONE_BEAT   = BL_W'(1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, GAP} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   streak;
  logic [BL_W-1:0] remain;
  logic [24:0]     addr;
  logic            grant_rd, grant_wr, last_ack, in_burst;

  assign in_burst = (state == RD_BURST) || (state == WR_BURST);

  // Arbitration in IDLE and burst sequencing
  always_comb begin
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    last_ack  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sdr_init_done) begin
          // reads win unless a pending write has already waited out the streak
          if (rd_req && (!wr_req || streak != STREAK_MAX)) begin
            grant_rd  = 1'b1;
            state_nxt = RD_BURST;
          end else if (wr_req) begin
            grant_wr  = 1'b1;
            state_nxt = WR_BURST;
          end
        end
      end
      RD_BURST, WR_BURST: begin
        if (wb_ack_i && remain == ONE_BEAT) begin
          last_ack  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Latch the winner's address/length, then walk them per acked beat
  always_ff @(posedge wb_clk_i or negedge RESETN) begin
    if (!RESETN) begin
      addr   <= '0;
      remain <= '0;
    end else if (grant_rd) begin
      addr   <= rd_addr;
      remain <= (rd_len == '0) ? ONE_BEAT : rd_len;
    end else if (grant_wr) begin
      addr   <= wr_addr;
      remain <= (wr_len == '0) ? ONE_BEAT : wr_len;
    end else if (in_burst && wb_ack_i) begin
      addr   <= addr + ADDR_STEP;
      remain <= remain - ONE_BEAT;
    end
  end

  // Count consecutive read wins taken while a write was waiting
  always_ff @(posedge wb_clk_i or negedge RESETN) begin
    if (!RESETN) begin
      streak <= '0;
    end else if (grant_rd) begin
      if (!wr_req)                  streak <= '0;
      else if (streak != STREAK_MAX) streak <= streak + SW'(1);
    end else if (grant_wr) begin
      streak <= '0;
    end
  end

  // Registered read data return and completion pulses
  always_ff @(posedge wb_clk_i or negedge RESETN) begin
    if (!RESETN) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      rd_valid <= (state == RD_BURST) && wb_ack_i;
      rd_done  <= (state == RD_BURST) && last_ack;
      wr_done  <= (state == WR_BURST) && last_ack;
      if ((state == RD_BURST) && wb_ack_i) rd_data <= wb_dat_i;
    end
  end

  assign rd_gnt    = grant_rd;
  assign wr_gnt    = grant_wr;
  assign wr_ack    = (state == WR_BURST) && wb_ack_i;
  assign wb_cyc_o  = in_burst;
  assign wb_stb_o  = in_burst;
  assign wb_we_o   = (state == WR_BURST);
  assign wb_addr_o = addr;
  assign wb_dat_o  = wr_data;
  assign wb_sel_o  = '1;
  assign wb_cti_o  = !in_burst          ? 3'b000 :
                     (remain > ONE_BEAT) ? 3'b010 : 3'b111;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Purpose: directed self-check of sdram_frame_arbiter (init gating, bursts, wait states, starvation, reset).
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: the bench acts as the Wishbone slave, acking every cycle or on alternate cycles.
module tb_sdram_frame_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        RESETN;
  logic        sdr_init_done;
  logic        rd_req, wr_req;
  logic [24:0] rd_addr, wr_addr;
  logic [8:0]  rd_len, wr_len;
  logic        rd_gnt, rd_valid, rd_done, wr_gnt, wr_ack, wr_done;
  logic [31:0] rd_data, wr_data, wb_dat_o, wb_dat_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [24:0] wb_addr_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;

  int total = 0;
  int bad   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  sdram_frame_arbiter dut (
    .wb_clk_i(wb_clk_i), .RESETN(RESETN), .sdr_init_done(sdr_init_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_done(wr_done),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  typedef struct {
    logic        is_wr;
    logic [24:0] addr;
    logic [8:0]  len;
    logic        ack_alt;
    int          beats;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request one burst from the table, act as slave and check every beat
  task automatic run_burst(input int idx);
    vec_t v;
    logic got, ack, prev_ack;
    int   beat, wr_acks;
    v = tbl[idx];
    @(negedge wb_clk_i);
    sdr_init_done = 1'b1;
    if (v.is_wr) begin
      wr_req = 1'b1; wr_addr = v.addr; wr_len = v.len;
    end else begin
      rd_req = 1'b1; rd_addr = v.addr; rd_len = v.len;
    end
    #1;
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if ((v.is_wr ? wr_gnt : rd_gnt) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge wb_clk_i); #1;
    end
    chk($sformatf("v%0d_gnt", idx), {31'd0, got}, 32'd1);
    chk($sformatf("v%0d_other_gnt", idx), {31'd0, v.is_wr ? rd_gnt : wr_gnt}, 32'd0);
    @(negedge wb_clk_i);
    rd_req = 1'b0; wr_req = 1'b0;
    beat = 0; wr_acks = 0; prev_ack = 1'b0; ack = 1'b0;
    for (int c = 0; c < 100 && beat < v.beats; c++) begin
      ack      = v.ack_alt ? c[0] : 1'b1;
      wb_ack_i = ack;
      wb_dat_i = 32'(beat + 1);
      wr_data  = 32'hA500_0000 + 32'(beat);
      #1;
      chk($sformatf("v%0d_cyc", idx), {31'd0, wb_cyc_o}, 32'd1);
      chk($sformatf("v%0d_stb", idx), {31'd0, wb_stb_o}, 32'd1);
      chk($sformatf("v%0d_we", idx), {31'd0, wb_we_o}, {31'd0, v.is_wr});
      chk($sformatf("v%0d_addr_b%0d", idx, beat), {7'd0, wb_addr_o}, {7'd0, v.addr} + 32'(4 * beat));
      chk($sformatf("v%0d_cti_b%0d", idx, beat), {29'd0, wb_cti_o},
          (beat == v.beats - 1) ? 32'd7 : 32'd2);
      chk($sformatf("v%0d_sel", idx), {28'd0, wb_sel_o}, 32'hF);
      if (v.is_wr) begin
        chk($sformatf("v%0d_wr_ack", idx), {31'd0, wr_ack}, {31'd0, ack});
        chk($sformatf("v%0d_dat_o", idx), wb_dat_o, 32'hA500_0000 + 32'(beat));
        if (wr_ack) wr_acks++;
      end else begin
        chk($sformatf("v%0d_rd_valid", idx), {31'd0, rd_valid}, {31'd0, prev_ack});
        if (prev_ack) chk($sformatf("v%0d_rd_data", idx), rd_data, 32'(beat));
      end
      chk($sformatf("v%0d_early_done", idx), {30'd0, rd_done, wr_done}, 32'd0);
      prev_ack = ack;
      if (ack) beat++;
      @(negedge wb_clk_i);
    end
    chk($sformatf("v%0d_beats", idx), 32'(beat), 32'(v.beats));
    wb_ack_i = 1'b0;
    #1;
    chk($sformatf("v%0d_end_cyc", idx), {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk($sformatf("v%0d_end_cti", idx), {29'd0, wb_cti_o}, 32'd0);
    chk($sformatf("v%0d_done", idx), {30'd0, rd_done, wr_done}, v.is_wr ? 32'd1 : 32'd2);
    chk($sformatf("v%0d_wr_ack_end", idx), {31'd0, wr_ack}, 32'd0);
    if (v.is_wr) begin
      chk($sformatf("v%0d_wr_acks", idx), 32'(wr_acks), 32'(v.beats));
    end else begin
      chk($sformatf("v%0d_last_valid", idx), {31'd0, rd_valid}, 32'd1);
      chk($sformatf("v%0d_last_data", idx), rd_data, 32'(v.beats));
    end
    @(negedge wb_clk_i); #1;
    chk($sformatf("v%0d_gap", idx), {28'd0, wb_cyc_o, rd_done, wr_done, rd_valid}, 32'd0);
  endtask

  initial begin
    logic [9:0] exp_w;
    int ng, last;

    tbl[0] = '{1'b0, 25'h100,     9'd4, 1'b0, 4};
    tbl[1] = '{1'b1, 25'h2000,    9'd3, 1'b1, 3};
    tbl[2] = '{1'b0, 25'h40,      9'd0, 1'b0, 1};
    tbl[3] = '{1'b1, 25'h80,      9'd1, 1'b1, 1};
    tbl[4] = '{1'b0, 25'h1FFFFFC, 9'd1, 1'b1, 1};
    tbl[5] = '{1'b1, 25'h300,     9'd0, 1'b0, 1};

    RESETN = 1'b0; sdr_init_done = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0;
    rd_len = '0; wr_len = '0; wr_data = '0; wb_ack_i = 1'b0; wb_dat_i = '0;

    // reset state
    repeat (3) @(negedge wb_clk_i);
    #1;
    chk("rst_bus", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_addr", {7'd0, wb_addr_o}, 32'd0);
    chk("rst_cti", {29'd0, wb_cti_o}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_pulses", {26'd0, rd_gnt, rd_valid, rd_done, wr_gnt, wr_ack, wr_done}, 32'd0);

    // init gating: request held with sdr_init_done low
    @(negedge wb_clk_i);
    RESETN = 1'b1;
    rd_req = 1'b1; rd_addr = 25'h100; rd_len = 9'd4;
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rd_gnt || wb_cyc_o) ng++;
      @(negedge wb_clk_i);
    end
    chk("init_block", 32'(ng), 32'd0);

    // table of bursts (entry 0 also completes the init release)
    for (int i = 0; i < 6; i++) run_burst(i);

    // starvation: both requesting, single-beat bursts
    @(negedge wb_clk_i);
    rd_req = 1'b1; wr_req = 1'b1; rd_len = 9'd1; wr_len = 9'd1;
    rd_addr = 25'h500; wr_addr = 25'h600;
    exp_w = 10'b10_0001_0000;
    ng = 0; last = 0;
    for (int c = 0; c < 100 && ng < 10; c++) begin
      wb_ack_i = wb_cyc_o;
      #1;
      if (rd_gnt || wr_gnt) begin
        chk($sformatf("starve_order_%0d", ng), {30'd0, rd_gnt, wr_gnt}, exp_w[ng] ? 32'd1 : 32'd2);
        if (ng > 0) chk($sformatf("starve_spacing_%0d", ng), 32'(c - last), 32'd3);
        last = c;
        ng++;
      end
      @(negedge wb_clk_i);
    end
    chk("starve_grants", 32'(ng), 32'd10);
    rd_req = 1'b0; wr_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wb_ack_i = wb_cyc_o;
      @(negedge wb_clk_i);
    end
    wb_ack_i = 1'b0;
    #1;
    chk("starve_idle", {31'd0, wb_cyc_o}, 32'd0);

    // reset in the middle of an 8-beat read
    @(negedge wb_clk_i);
    rd_req = 1'b1; rd_addr = 25'h400; rd_len = 9'd8;
    #1;
    chk("mid_gnt", {31'd0, rd_gnt}, 32'd1);
    @(negedge wb_clk_i);
    rd_req = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h77;
    @(negedge wb_clk_i);
    wb_ack_i = 1'b0;
    #1;
    chk("mid_beat2_addr", {7'd0, wb_addr_o}, 32'h404);
    chk("mid_beat2_cyc", {31'd0, wb_cyc_o}, 32'd1);
    RESETN = 1'b0;
    #1;
    chk("mid_rst_bus", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("mid_rst_addr", {7'd0, wb_addr_o}, 32'd0);
    chk("mid_rst_rd_data", rd_data, 32'd0);
    ng = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge wb_clk_i); #1;
      if (rd_done || wr_done || wb_cyc_o) ng++;
    end
    chk("mid_no_done", 32'(ng), 32'd0);
    @(negedge wb_clk_i);
    RESETN = 1'b1;
    run_burst(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
